// File: rtl/bitstream_serializer.sv
// Purpose: serialize DATA_W-bit AXI-Stream words into a 1-bit AXI-Stream, carrying word tlast onto the final bit.
// Latency: word accepted at edge N, first bit valid in the following cycle; one bit per cycle sustained.
// Backpressure: bits hold while bitstream_tready=0; words_tready rises only in IDLE or on a consumed last bit.
module bitstream_serializer #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] words_tdata,
    input  logic              words_tvalid,
    output logic              words_tready,
    input  logic              words_tlast,
    output logic              bitstream_tdata,
    output logic              bitstream_tvalid,
    input  logic              bitstream_tready,
    output logic              bitstream_tlast,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_bits,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]  bit_idx;
    logic              held_tlast;

    logic last_bit;
    logic bit_hs;
    logic word_acc;

    assign last_bit = (bit_idx == LAST_IDX);
    assign bit_hs   = (state == SHIFT) && bitstream_tready;

    // Combinational from bitstream_tready so the next word loads on the same edge as the last bit.
    assign words_tready = (state == IDLE) || (last_bit && bitstream_tready);
    assign word_acc     = words_tvalid && words_tready;

    assign bitstream_tvalid = (state == SHIFT);
    assign bitstream_tdata  = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];
    assign bitstream_tlast  = (state == SHIFT) && held_tlast && last_bit;
    assign busy             = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_idx    <= '0;
            held_tlast <= 1'b0;
        end else if (word_acc) begin
            state      <= SHIFT;
            shift_q    <= words_tdata;
            bit_idx    <= '0;
            held_tlast <= words_tlast;
        end else if (bit_hs) begin
            if (last_bit) begin
                state <= IDLE;
            end else begin
                bit_idx <= bit_idx + IDX_W'(1);
                if (MSB_FIRST != 0) begin
                    shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                end else begin
                    shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                end
            end
        end
    end

    // Frame end clears the count on the same edge that emits the tlast bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_bits <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= bit_hs && bitstream_tlast;
            if (bit_hs) begin
                if (bitstream_tlast) begin
                    frame_bits <= '0;
                end else if (frame_bits != {CNT_W{1'b1}}) begin
                    frame_bits <= frame_bits + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bitstream_serializer.sv
// Directed and random checks of bitstream_serializer: LSB-first, MSB-first and a narrow-counter instance share stimulus.
module tb_bitstream_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] words_tdata;
    logic       words_tvalid;
    logic       words_tlast;
    logic       bs_tready;

    logic        wrdy0, tdata0, tvalid0, tlast0, busy0, done0;
    logic [15:0] fb0;
    logic        wrdy1, tdata1, tvalid1, tlast1, busy1, done1;
    logic [15:0] fb1;
    logic        wrdy2, tdata2, tvalid2, tlast2, busy2, done2;
    logic [2:0]  fb2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bitstream_serializer #(.DATA_W(8), .MSB_FIRST(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .words_tdata(words_tdata), .words_tvalid(words_tvalid), .words_tready(wrdy0), .words_tlast(words_tlast),
        .bitstream_tdata(tdata0), .bitstream_tvalid(tvalid0), .bitstream_tready(bs_tready), .bitstream_tlast(tlast0),
        .busy(busy0), .frame_bits(fb0), .frame_done(done0)
    );

    bitstream_serializer #(.DATA_W(8), .MSB_FIRST(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst),
        .words_tdata(words_tdata), .words_tvalid(words_tvalid), .words_tready(wrdy1), .words_tlast(words_tlast),
        .bitstream_tdata(tdata1), .bitstream_tvalid(tvalid1), .bitstream_tready(bs_tready), .bitstream_tlast(tlast1),
        .busy(busy1), .frame_bits(fb1), .frame_done(done1)
    );

    bitstream_serializer #(.DATA_W(8), .MSB_FIRST(0), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst),
        .words_tdata(words_tdata), .words_tvalid(words_tvalid), .words_tready(wrdy2), .words_tlast(words_tlast),
        .bitstream_tdata(tdata2), .bitstream_tvalid(tvalid2), .bitstream_tready(bs_tready), .bitstream_tlast(tlast2),
        .busy(busy2), .frame_bits(fb2), .frame_done(done2)
    );

    // Presents one word at the next falling edge; it is taken at the following rising edge.
    task automatic send_word(input logic [7:0] d, input logic l);
        @(negedge clk);
        words_tdata  = d;
        words_tlast  = l;
        words_tvalid = 1'b1;
        @(negedge clk);
        words_tvalid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({tvalid0, tlast0, busy0, done0, fb0} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got tvalid=%0b tlast=%0b busy=%0b done=%0b fb=%0d want all 0",
                     tvalid0, tlast0, busy0, done0, fb0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (wrdy0 !== 1'b1 || tvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got words_tready=%0b tvalid=%0b want 1/0", wrdy0, tvalid0);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w = 8'hA5;
        send_word(w, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tvalid0 !== 1'b1 || tdata0 !== w[i] || tlast0 !== 1'b0 || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL single_bit%0d: got v=%0b d=%0b l=%0b busy=%0b want 1/%0b/0/1",
                         i, tvalid0, tdata0, tlast0, busy0, w[i]);
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (tvalid0 !== 1'b0 || busy0 !== 1'b0 || fb0 !== 16'd8) begin
            errors++;
            $display("FAIL single_end: got v=%0b busy=%0b fb=%0d want 0/0/8", tvalid0, busy0, fb0);
        end
        checks++;
        if (fb2 !== 3'd7) begin
            errors++;
            $display("FAIL single_saturate: got fb=%0d want 7", fb2);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp = {8'h80, 8'h01};
        int done_cnt = 0;
        @(negedge clk);
        words_tdata  = 8'h01;
        words_tlast  = 1'b0;
        words_tvalid = 1'b1;
        @(negedge clk);
        words_tdata  = 8'h80;
        words_tlast  = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tvalid0 !== 1'b1 || tdata0 !== exp[i] || tlast0 !== (i == 15)) begin
                errors++;
                $display("FAIL b2b_bit%0d: got v=%0b d=%0b l=%0b want 1/%0b/%0b",
                         i, tvalid0, tdata0, tlast0, exp[i], (i == 15));
            end
            if (i == 7) begin
                checks++;
                if (wrdy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_words_tready: got %0b want 1", wrdy0);
                end
            end
            if (done0 === 1'b1) done_cnt++;
            @(negedge clk);
            if (i == 7) words_tvalid = 1'b0;
            #1;
        end
        checks++;
        if (done0 !== 1'b1 || done_cnt != 0 || fb0 !== 16'd0 || tvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frame_end: got done=%0b early_pulses=%0d fb=%0d v=%0b want 1/0/0/0",
                     done0, done_cnt, fb0, tvalid0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_width: got %0b want 0", done0);
        end
    endtask

    task automatic test_stall();
        logic [7:0] w = 8'hC3;
        send_word(w, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                bs_tready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    checks++;
                    if (tvalid0 !== 1'b1 || tdata0 !== w[3] || tlast0 !== 1'b0 || wrdy0 !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold%0d: got v=%0b d=%0b l=%0b wrdy=%0b want 1/%0b/0/0",
                                 s, tvalid0, tdata0, tlast0, wrdy0, w[3]);
                    end
                    @(negedge clk);
                    #1;
                end
                bs_tready = 1'b1;
            end
            checks++;
            if (tvalid0 !== 1'b1 || tdata0 !== w[i] || tlast0 !== (i == 7)) begin
                errors++;
                $display("FAIL stall_bit%0d: got v=%0b d=%0b l=%0b want 1/%0b/%0b",
                         i, tvalid0, tdata0, tlast0, w[i], (i == 7));
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (tvalid0 !== 1'b0 || fb0 !== 16'd0) begin
            errors++;
            $display("FAIL stall_end: got v=%0b fb=%0d want 0/0", tvalid0, fb0);
        end
    endtask

    task automatic test_msb_first();
        send_word(8'h01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tvalid1 !== 1'b1 || tdata1 !== (i == 7) || tlast1 !== (i == 7)) begin
                errors++;
                $display("FAIL msb_bit%0d: got v=%0b d=%0b l=%0b want 1/%0b/%0b",
                         i, tvalid1, tdata1, tlast1, (i == 7), (i == 7));
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w = 8'h0F;
        send_word(8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (fb0 !== 16'd5 || tvalid0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_before: got fb=%0d v=%0b want 5/1", fb0, tvalid0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tvalid0 !== 1'b0 || busy0 !== 1'b0 || fb0 !== 16'd0 || tvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got v=%0b busy=%0b fb=%0d v1=%0b want 0/0/0/0",
                     tvalid0, busy0, fb0, tvalid1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (tvalid0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: got v=%0b busy=%0b want 0/0", tvalid0, busy0);
        end
        send_word(w, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tvalid0 !== 1'b1 || tdata0 !== w[i] || tlast0 !== (i == 7)) begin
                errors++;
                $display("FAIL midrst_bit%0d: got v=%0b d=%0b l=%0b want 1/%0b/%0b",
                         i, tvalid0, tdata0, tlast0, w[i], (i == 7));
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_stress();
        bit [1:0]    q0[$];
        bit [1:0]    q1[$];
        bit [1:0]    e0;
        bit [1:0]    e1;
        int          sent = 0;
        int          cyc = 0;
        logic [15:0] fb_exp = 16'd0;
        logic        done_exp = 1'b0;
        logic        acc = 1'b0;
        logic        stalled = 1'b0;
        logic [1:0]  prev0 = 2'b00;
        logic [7:0]  d;
        @(negedge clk);
        while ((sent < 1000 || q0.size() != 0) && cyc < 40000) begin
            if (acc) words_tvalid = 1'b0;
            if (!words_tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                words_tdata  = 8'($urandom_range(0, 255));
                words_tlast  = ($urandom_range(0, 7) == 0);
                words_tvalid = 1'b1;
            end
            bs_tready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (fb0 !== fb_exp || done0 !== done_exp) begin
                errors++;
                $display("FAIL stress_count cyc%0d: got fb=%0d done=%0b want %0d/%0b", cyc, fb0, done0, fb_exp, done_exp);
            end
            if (stalled) begin
                checks++;
                if (tvalid0 !== 1'b1 || {tdata0, tlast0} !== prev0) begin
                    errors++;
                    $display("FAIL stress_stable cyc%0d: got v=%0b d/l=%0b want 1/%0b", cyc, tvalid0, {tdata0, tlast0}, prev0);
                end
            end
            done_exp = 1'b0;
            if (tvalid0 === 1'b1 && bs_tready) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL stress_spurious cyc%0d: got bit with no word pending want none", cyc);
                end else begin
                    e0 = q0.pop_front();
                    e1 = q1.pop_front();
                    if ({tdata0, tlast0} !== e0 || {tdata1, tlast1} !== e1) begin
                        errors++;
                        $display("FAIL stress_bit cyc%0d: got lsb=%0b msb=%0b want %0b/%0b",
                                 cyc, {tdata0, tlast0}, {tdata1, tlast1}, e0, e1);
                    end
                    if (e0[0]) begin
                        fb_exp   = 16'd0;
                        done_exp = 1'b1;
                    end else if (fb_exp != 16'hFFFF) begin
                        fb_exp = fb_exp + 16'd1;
                    end
                end
            end
            stalled = (tvalid0 === 1'b1) && !bs_tready;
            prev0   = {tdata0, tlast0};
            acc     = words_tvalid && (wrdy0 === 1'b1);
            if (acc) begin
                d = words_tdata;
                for (int b = 0; b < 8; b++) begin
                    q0.push_back({d[b], words_tlast && (b == 7)});
                    q1.push_back({d[7-b], words_tlast && (b == 7)});
                end
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        words_tvalid = 1'b0;
        bs_tready    = 1'b1;
        checks++;
        if (sent != 1000 || q0.size() != 0) begin
            errors++;
            $display("FAIL stress_complete: got sent=%0d pending_bits=%0d want 1000/0", sent, q0.size());
        end
    endtask

    initial begin
        rst          = 1'b0;
        words_tdata  = 8'h00;
        words_tvalid = 1'b0;
        words_tlast  = 1'b0;
        bs_tready    = 1'b1;
        #2;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_msb_first();
        test_reset_mid_word();
        test_stress();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
